// File: rtl/sprite_blitter.sv
// sprite_blitter
//   Framebuffer writer for the player sprite. Each vblank update pulse
//   erases the sprite at its previous position (when there is one) and
//   redraws it at the newly sampled position. Writes go out through a
//   we/ready handshake into an RRRGGGBB framebuffer. Sprite rows come from
//   a bitmap ROM with one cycle of read latency.
//
// Ports
//   clk_pixel  in   pixel clock, the only clock
//   arst       in   synchronous active-high reset
//   update     in   1-cycle vblank pulse that starts a blit
//   player_x   in   sprite left column, sampled with update
//   player_y   in   sprite top row, sampled with update
//   rom_addr   out  bitmap row index
//   rom_row    in   bitmap row, valid one cycle after rom_addr
//                   (bit SPR_W-1-c is column c)
//   fb_we      out  framebuffer write request
//   fb_addr    out  framebuffer write address, y*DISPLAY_H + x
//   fb_data    out  framebuffer write colour
//   fb_ready   in   write accepted when fb_we && fb_ready
//   busy       out  high whenever a blit is in progress
//   done       out  1-cycle pulse when the blit completes
//   overrun    out  1-cycle pulse when update arrives while busy

module sprite_blitter #(
    parameter int          DISPLAY_H = 640,
    parameter int          DISPLAY_V = 480,
    parameter int          SPR_W     = 16,
    parameter int          SPR_H     = 8,
    parameter int          ROW_W     = 3,
    parameter int          ADDR_W    = 19,
    parameter logic [7:0]  FG_COLOUR = 8'b000_111_00,
    parameter logic [7:0]  BG_COLOUR = 8'h00
) (
    input  logic              clk_pixel,
    input  logic              arst,
    input  logic              update,
    input  logic [9:0]        player_x,
    input  logic [9:0]        player_y,
    output logic [ROW_W-1:0]  rom_addr,
    input  logic [SPR_W-1:0]  rom_row,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    input  logic              fb_ready,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam int COL_W = $clog2(SPR_W);

    typedef enum logic [2:0] {IDLE, ERASE, FETCH, LOAD, DRAW, DONE} state_t;

    state_t             state;
    logic [9:0]         cur_x;
    logic [9:0]         cur_y;
    logic [9:0]         prev_x;
    logic [9:0]         prev_y;
    logic               prev_valid;
    logic [ROW_W-1:0]   r;
    logic [COL_W-1:0]   c;
    // Holds the pixels still to be drawn in this row, next column in the MSB.
    logic [SPR_W-1:0]   row_bits;

    logic               stalled;
    logic               last_col;
    logic               last_row;
    logic [ROW_W-1:0]   step_r;
    logic [COL_W-1:0]   step_c;

    // Pixel coordinates are formed at 11 bits so a sprite hanging off the
    // right or bottom edge is clipped instead of wrapping back on screen.
    function automatic logic in_view(input logic [9:0]       x0,
                                     input logic [9:0]       y0,
                                     input logic [ROW_W-1:0] rr,
                                     input logic [COL_W-1:0] cc);
        logic [10:0] px;
        logic [10:0] py;
        px = {1'b0, x0} + 11'(cc);
        py = {1'b0, y0} + 11'(rr);
        return (px < 11'(DISPLAY_H)) && (py < 11'(DISPLAY_V));
    endfunction

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [9:0]       x0,
                                                   input logic [9:0]       y0,
                                                   input logic [ROW_W-1:0] rr,
                                                   input logic [COL_W-1:0] cc);
        logic [10:0] px;
        logic [10:0] py;
        px = {1'b0, x0} + 11'(cc);
        py = {1'b0, y0} + 11'(rr);
        return ADDR_W'(py) * ADDR_W'(DISPLAY_H) + ADDR_W'(px);
    endfunction

    // A pending write holds the visit in place until the framebuffer takes it.
    assign stalled  = fb_we && !fb_ready;
    assign last_col = (c == COL_W'(SPR_W - 1));
    assign last_row = (r == ROW_W'(SPR_H - 1));
    assign step_c   = last_col ? '0 : c + COL_W'(1);
    assign step_r   = last_col ? r + ROW_W'(1) : r;

    // An update that lands while a blit is running is reported and dropped.
    assign overrun  = update && busy;

    // Blit sequencer. The write port is registered, so every transition that
    // starts a new pixel visit also loads fb_we/fb_addr/fb_data for that
    // visit. fb_data only changes when a write is actually requested.
    always_ff @(posedge clk_pixel) begin
        if (arst) begin
            state      <= IDLE;
            cur_x      <= '0;
            cur_y      <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            r          <= '0;
            c          <= '0;
            row_bits   <= '0;
            rom_addr   <= '0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (update) begin
                        cur_x <= player_x;
                        cur_y <= player_y;
                        r     <= '0;
                        c     <= '0;
                        busy  <= 1'b1;
                        if (prev_valid) begin
                            state   <= ERASE;
                            fb_we   <= in_view(prev_x, prev_y, '0, '0);
                            fb_addr <= pix_addr(prev_x, prev_y, '0, '0);
                            if (in_view(prev_x, prev_y, '0, '0))
                                fb_data <= BG_COLOUR;
                        end else begin
                            state    <= FETCH;
                            rom_addr <= '0;
                        end
                    end
                end

                ERASE: begin
                    if (!stalled) begin
                        if (last_row && last_col) begin
                            state    <= FETCH;
                            r        <= '0;
                            c        <= '0;
                            rom_addr <= '0;
                            fb_we    <= 1'b0;
                        end else begin
                            r       <= step_r;
                            c       <= step_c;
                            fb_we   <= in_view(prev_x, prev_y, step_r, step_c);
                            fb_addr <= pix_addr(prev_x, prev_y, step_r, step_c);
                            if (in_view(prev_x, prev_y, step_r, step_c))
                                fb_data <= BG_COLOUR;
                        end
                    end
                end

                FETCH: begin
                    state <= LOAD;
                end

                // rom_row is valid now; column 0 uses it directly and the
                // rest is kept pre-shifted for the following columns.
                LOAD: begin
                    state    <= DRAW;
                    c        <= '0;
                    row_bits <= rom_row << 1;
                    fb_we    <= rom_row[SPR_W-1] && in_view(cur_x, cur_y, r, '0);
                    fb_addr  <= pix_addr(cur_x, cur_y, r, '0);
                    if (rom_row[SPR_W-1] && in_view(cur_x, cur_y, r, '0))
                        fb_data <= FG_COLOUR;
                end

                DRAW: begin
                    if (!stalled) begin
                        if (last_col) begin
                            fb_we <= 1'b0;
                            c     <= '0;
                            if (last_row) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                r        <= step_r;
                                rom_addr <= step_r;
                                state    <= FETCH;
                            end
                        end else begin
                            c        <= step_c;
                            row_bits <= row_bits << 1;
                            fb_we    <= row_bits[SPR_W-1] && in_view(cur_x, cur_y, r, step_c);
                            fb_addr  <= pix_addr(cur_x, cur_y, r, step_c);
                            if (row_bits[SPR_W-1] && in_view(cur_x, cur_y, r, step_c))
                                fb_data <= FG_COLOUR;
                        end
                    end
                end

                DONE: begin
                    prev_x     <= cur_x;
                    prev_y     <= cur_y;
                    prev_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    fb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb_sprite_blitter
//   Self-checking bench for sprite_blitter. A behavioural model turns every
//   accepted update into the list of per-cycle pixel visits the blit must
//   produce (erase rectangle, then fetch/load/draw per row, then done), and a
//   single compare process walks that list against the DUT every cycle,
//   holding on a visit while a write is stalled. Directed scenarios pin the
//   model with hand-computed addresses, counts and latencies; a randomized
//   loop then exercises positions, bitmaps and fb_ready.

module tb_sprite_blitter;

    logic        clk_pixel;
    logic        arst;
    logic        update;
    logic [9:0]  player_x;
    logic [9:0]  player_y;
    logic [2:0]  rom_addr;
    logic [15:0] rom_row;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_ready;
    logic        busy;
    logic        done;
    logic        overrun;

    sprite_blitter dut (
        .clk_pixel (clk_pixel),
        .arst      (arst),
        .update    (update),
        .player_x  (player_x),
        .player_y  (player_y),
        .rom_addr  (rom_addr),
        .rom_row   (rom_row),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_data   (fb_data),
        .fb_ready  (fb_ready),
        .busy      (busy),
        .done      (done),
        .overrun   (overrun)
    );

    typedef struct {
        bit we;
        int addr;
        int data;
        bit fetch;
        int row;
        bit fin;
    } slot_t;

    int    checks   = 0;
    int    failures = 0;

    logic [15:0] rom_mem [0:7];
    bit    rand_ready = 0;

    slot_t q[$];
    slot_t head;
    bit    exp_busy;
    bit    model_valid = 0;
    bit    m_prev_valid = 0;
    int    m_prev_x = 0;
    int    m_prev_y = 0;
    int    m_cur_x = 0;
    int    m_cur_y = 0;
    int    m_last_data = 0;
    int    m_last_rom = 0;

    int    cyc = 0;
    int    upd_cyc = 0;
    int    stall_cnt = 0;
    int    last_latency = -1;
    int    last_stalls = 0;
    int    overrun_cnt = 0;
    int    wr_addr_q[$];
    int    wr_data_q[$];

    // Clock
    initial begin
        clk_pixel = 1'b0;
        forever #5 clk_pixel = ~clk_pixel;
    end

    // Registered bitmap ROM
    initial begin
        forever begin
            @(posedge clk_pixel);
            rom_row <= rom_mem[rom_addr];
        end
    end

    // Framebuffer acceptance: always ready, or a coin toss per cycle
    initial begin
        fb_ready = 1'b1;
        forever begin
            @(posedge clk_pixel);
            #1;
            fb_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Expected visit list for one blit, straight from the sprite rules.
    task automatic buildBlit(input int nx, input int ny);
        slot_t s;
        int px;
        int py;
        m_cur_x = nx;
        m_cur_y = ny;
        if (m_prev_valid) begin
            for (int rr = 0; rr < 8; rr++) begin
                for (int cc = 0; cc < 16; cc++) begin
                    s = '{default: 0};
                    px = m_prev_x + cc;
                    py = m_prev_y + rr;
                    s.we = (px < 640) && (py < 480);
                    s.addr = py * 640 + px;
                    s.data = 0;
                    q.push_back(s);
                end
            end
        end
        for (int rr = 0; rr < 8; rr++) begin
            s = '{default: 0};
            s.fetch = 1'b1;
            s.row = rr;
            q.push_back(s);
            s = '{default: 0};
            q.push_back(s);
            for (int cc = 0; cc < 16; cc++) begin
                s = '{default: 0};
                px = nx + cc;
                py = ny + rr;
                s.we = rom_mem[rr][15 - cc] && (px < 640) && (py < 480);
                s.addr = py * 640 + px;
                s.data = 8'h1C;
                q.push_back(s);
            end
        end
        s = '{default: 0};
        s.fin = 1'b1;
        q.push_back(s);
    endtask

    // Single compare process, sampling away from the active edge.
    initial begin
        forever begin
            @(negedge clk_pixel);
            cyc++;
            exp_busy = (q.size() != 0);
            if (exp_busy) head = q[0];
            else          head = '{default: 0};
            if (model_valid) begin
                if (head.we)    m_last_data = head.data;
                if (head.fetch) m_last_rom = head.row;
                checkOutput("busy", busy, exp_busy);
                checkOutput("done", done, head.fin);
                checkOutput("fb_we", fb_we, head.we);
                checkOutput("overrun", overrun, update && exp_busy);
                checkOutput("fb_data", fb_data, m_last_data);
                checkOutput("rom_addr", rom_addr, m_last_rom);
                if (head.we) checkOutput("fb_addr", fb_addr, head.addr);
            end
            if (fb_we === 1'b1 && fb_ready) begin
                wr_addr_q.push_back(int'(fb_addr));
                wr_data_q.push_back(int'(fb_data));
            end
            if (done === 1'b1) begin
                last_latency = cyc - upd_cyc;
                last_stalls  = stall_cnt;
            end
            if (overrun === 1'b1) overrun_cnt++;

            if (arst) begin
                q.delete();
                m_prev_valid = 0;
                m_prev_x = 0;
                m_prev_y = 0;
                m_last_data = 0;
                m_last_rom = 0;
                model_valid = 1;
            end else if (model_valid) begin
                if (exp_busy) begin
                    if (head.we && !fb_ready) begin
                        stall_cnt++;
                    end else begin
                        void'(q.pop_front());
                        if (head.fin) begin
                            m_prev_valid = 1;
                            m_prev_x = m_cur_x;
                            m_prev_y = m_cur_y;
                        end
                    end
                end
                if (update && !exp_busy) begin
                    buildBlit(int'(player_x), int'(player_y));
                    upd_cyc = cyc;
                    stall_cnt = 0;
                end
            end
        end
    end

    task automatic applyStimulus(input int x, input int y);
        player_x = 10'(x);
        player_y = 10'(y);
        update = 1'b1;
        @(posedge clk_pixel);
        #1;
        update = 1'b0;
    endtask

    task automatic waitIdle(input int limit);
        int n;
        n = 0;
        while (q.size() != 0 && n < limit) begin
            @(posedge clk_pixel);
            #1;
            n++;
        end
        if (q.size() != 0) checkOutput("blit_timeout", 1, 0);
        @(posedge clk_pixel);
        #1;
    endtask

    task automatic clearTally();
        wr_addr_q.delete();
        wr_data_q.delete();
        last_latency = -1;
        overrun_cnt = 0;
    endtask

    task automatic doReset();
        arst = 1'b1;
        repeat (2) @(posedge clk_pixel);
        #1;
        arst = 1'b0;
    endtask

    task automatic fillRom(input logic [15:0] pattern);
        for (int i = 0; i < 8; i++) rom_mem[i] = pattern;
    endtask

    initial begin
        int fg;
        int n;
        arst = 1'b1;
        update = 1'b0;
        player_x = '0;
        player_y = '0;
        fillRom(16'hFFFF);
        repeat (3) @(posedge clk_pixel);
        #1;
        arst = 1'b0;
        @(posedge clk_pixel);
        #1;
        checkOutput("reset_fb_addr", fb_addr, 0);
        checkOutput("reset_busy", busy, 0);

        // Plain draw, no erase
        clearTally();
        applyStimulus(100, 50);
        waitIdle(1000);
        checkOutput("t1_writes", wr_addr_q.size(), 128);
        checkOutput("t1_first_addr", wr_addr_q[0], 32100);
        checkOutput("t1_last_addr", wr_addr_q[127], 36595);
        checkOutput("t1_first_data", wr_data_q[0], 8'h1C);
        checkOutput("t1_latency", last_latency, 145);

        // Move right by one: full erase, then redraw
        clearTally();
        applyStimulus(101, 50);
        waitIdle(1000);
        checkOutput("t2_writes", wr_addr_q.size(), 256);
        checkOutput("t2_first_addr", wr_addr_q[0], 32100);
        checkOutput("t2_first_data", wr_data_q[0], 8'h00);
        checkOutput("t2_last_erase", wr_addr_q[127], 36595);
        checkOutput("t2_first_draw", wr_addr_q[128], 32101);
        checkOutput("t2_draw_data", wr_data_q[128], 8'h1C);
        checkOutput("t2_latency", last_latency, 273);

        // Bottom-right corner clipping
        clearTally();
        applyStimulus(632, 476);
        waitIdle(1000);
        fg = 0;
        foreach (wr_data_q[i]) if (wr_data_q[i] == 8'h1C) fg++;
        checkOutput("t3_writes", wr_addr_q.size(), 160);
        checkOutput("t3_fg_writes", fg, 32);
        checkOutput("t3_last_addr", wr_addr_q[wr_addr_q.size() - 1], 307199);

        // Striped bitmap, fresh from reset
        doReset();
        fillRom(16'hAAAA);
        clearTally();
        applyStimulus(200, 100);
        waitIdle(1000);
        checkOutput("t4_writes", wr_addr_q.size(), 64);
        checkOutput("t4_first_addr", wr_addr_q[0], 64200);
        checkOutput("t4_second_addr", wr_addr_q[1], 64202);
        checkOutput("t4_latency", last_latency, 145);

        // Random backpressure
        doReset();
        fillRom(16'hFFFF);
        clearTally();
        rand_ready = 1;
        applyStimulus(100, 50);
        waitIdle(3000);
        rand_ready = 0;
        checkOutput("t5_writes", wr_addr_q.size(), 128);
        checkOutput("t5_first_addr", wr_addr_q[0], 32100);
        checkOutput("t5_last_addr", wr_addr_q[127], 36595);
        checkOutput("t5_latency", last_latency, 145 + last_stalls);

        // Update during DRAW is ignored
        clearTally();
        applyStimulus(300, 200);
        repeat (150) @(posedge clk_pixel);
        #1;
        applyStimulus(5, 5);
        waitIdle(1000);
        checkOutput("t6_overrun_cnt", overrun_cnt, 1);
        checkOutput("t6_latency", last_latency, 273);

        // Update coincident with DONE is an overrun, not a restart
        clearTally();
        applyStimulus(310, 210);
        n = 0;
        while (q.size() > 1 && n < 1000) begin
            @(posedge clk_pixel);
            #1;
            n++;
        end
        applyStimulus(0, 0);
        waitIdle(1000);
        checkOutput("t6_done_overrun", overrun_cnt, 1);
        checkOutput("t6_done_idle", busy, 0);

        // Reset mid-DRAW drops the blit and the erase history
        clearTally();
        applyStimulus(320, 220);
        repeat (200) @(posedge clk_pixel);
        #1;
        arst = 1'b1;
        @(posedge clk_pixel);
        #1;
        arst = 1'b0;
        checkOutput("t6_rst_we", fb_we, 0);
        checkOutput("t6_rst_busy", busy, 0);
        clearTally();
        applyStimulus(50, 60);
        waitIdle(1000);
        checkOutput("t6_no_erase_latency", last_latency, 145);
        checkOutput("t6_no_erase_writes", wr_addr_q.size(), 128);

        // Randomized blits
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < 8; i++) rom_mem[i] = 16'($urandom);
            rand_ready = it[0];
            applyStimulus(int'($urandom_range(0, 700)), int'($urandom_range(0, 520)));
            waitIdle(3000);
        end
        rand_ready = 0;

        repeat (3) @(posedge clk_pixel);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
